// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
// Pure declarations; no logic, no latency.
// No handshakes live here.
package cpu_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [3:0] DFLT_ID_I = 4'd0;
    localparam logic [3:0] DFLT_ID_D = 4'd1;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bundles for the arbiter: one requester-side port and the AXI3 AR/R pair.
// Wires only; no latency.
// Requester: req held until gnt. AXI: standard valid/ready on AR and R.
interface rd_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic              rerr;

    modport master (output req, addr, len, size,
                    input  gnt, rvalid, rdata, rlast, rerr);
    modport slave  (input  req, addr, len, size,
                    output gnt, rvalid, rdata, rlast, rerr);
endinterface

interface axi_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache,
                           arprot, arvalid, rready,
                    input  arready, rid, rdata, rresp, rlast, rvalid);
    modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache,
                           arprot, arvalid, rready,
                    output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way request arbiter; bit 0 = port I, bit 1 = port D. Macro: AXI_RD_ARB_RR_EN.
// Grant is combinational from req; pointer (RR build only) moves on advance.
// No backpressure; caller pulses advance when it takes the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef AXI_RD_ARB_RR_EN
    // 1 when port D was granted last; reset means I went last so D wins a tie
    logic last_d_q, last_d_d;

    // On a tie the port not granted last wins
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_d_q ? 2'b01 : 2'b10;
        end
    end

    // Remember who was granted each time the grant is consumed
    always_comb begin
        last_d_d = last_d_q;
        if (advance && (gnt != 2'b00)) begin
            last_d_d = gnt[1];
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance};

    // Fixed priority: D always beats I
    always_comb begin
        gnt = req;
        if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 AR/R pair between fetch (I) and load (D); one burst in flight. Macro: AXI_RD_ARB_RR_EN.
// req in IDLE at N -> gnt+arvalid at N+1; arready at N+1 -> first beat at N+2; beats pass through combinationally.
// AR held stable until arready; rready only raised in DATA, dropped after rlast.
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] ID_I   = DFLT_ID_I,
    parameter logic [3:0] ID_D   = DFLT_ID_D
) (
    input  logic     aclk,
    input  logic     areset,
    rd_req_if.slave  i_port,
    rd_req_if.slave  d_port,
    axi_rd_if.master axi
);

    arb_state_t        state_q,   state_d;
    owner_t            owner_q,   owner_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q,  rready_d;
    logic              i_gnt_q,   i_gnt_d;
    logic              d_gnt_q,   d_gnt_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [3:0]        arlen_q,   arlen_d;
    logic [2:0]        arsize_q,  arsize_d;
    logic [3:0]        arid_q,    arid_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_adv;

    assign arb_req = {d_port.req, i_port.req};
    assign arb_adv = (state_q == IDLE) && (arb_req != 2'b00);

    rr_arb2 u_arb (
        .clk     (aclk),
        .rst     (areset),
        .req     (arb_req),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    // Next-state: latch the winner's AR payload, wait for arready, stream beats until rlast
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arid_d    = arid_q;
        i_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_gnt[1]) begin
                    owner_d   = OWN_D;
                    araddr_d  = d_port.addr;
                    arlen_d   = d_port.len;
                    arsize_d  = d_port.size;
                    arid_d    = ID_D;
                    arvalid_d = 1'b1;
                    d_gnt_d   = 1'b1;
                    state_d   = ADDR;
                end else if (arb_gnt[0]) begin
                    owner_d   = OWN_I;
                    araddr_d  = i_port.addr;
                    arlen_d   = i_port.len;
                    arsize_d  = i_port.size;
                    arid_d    = ID_I;
                    arvalid_d = 1'b1;
                    i_gnt_d   = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (axi.rvalid && axi.rlast) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs; reset abandons any burst in flight
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            i_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            i_gnt_q   <= i_gnt_d;
            d_gnt_q   <= d_gnt_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arid_q    <= arid_d;
        end
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    // Beat routing: only the owner sees R traffic, and only while in DATA
    logic i_sel, d_sel;
    assign i_sel = (state_q == DATA) && (owner_q == OWN_I);
    assign d_sel = (state_q == DATA) && (owner_q == OWN_D);

    assign i_port.gnt    = i_gnt_q;
    assign i_port.rvalid = i_sel && axi.rvalid;
    assign i_port.rdata  = i_sel ? axi.rdata : '0;
    assign i_port.rlast  = i_sel && axi.rlast;
    assign i_port.rerr   = i_sel && axi.rresp[1];

    assign d_port.gnt    = d_gnt_q;
    assign d_port.rvalid = d_sel && axi.rvalid;
    assign d_port.rdata  = d_sel ? axi.rdata : '0;
    assign d_port.rlast  = d_sel && axi.rlast;
    assign d_port.rerr   = d_sel && axi.rresp[1];

    // Single outstanding burst, so rid carries no routing information
    logic unused_ok;
    assign unused_ok = ^{axi.rid, axi.rresp[0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter (build with or without AXI_RD_ARB_RR_EN).
// A memory-side driver feeds AR/R with random stalls; expectations come from a
// request/grant model and the beats the bench itself sends.
module tb_axi_rd_arbiter;
    import cpu_axi_pkg::*;

`ifdef AXI_RD_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic aclk;
    logic areset;

    rd_req_if i_if ();
    rd_req_if d_if ();
    axi_rd_if axi_if ();

    axi_rd_arbiter dut (
        .aclk   (aclk),
        .areset (areset),
        .i_port (i_if),
        .d_port (d_if),
        .axi    (axi_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: which port was granted last, what is outstanding, held fields
    bit          last_d;
    bit          pend_i, pend_d;
    logic [31:0] f_addr [2];
    logic [3:0]  f_len  [2];
    logic [2:0]  f_size [2];
    int          ar_dly_fix = -1;
    int          rresp_fix  = -1;
    int          gaps[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s);
        f_addr[p] = a;
        f_len[p]  = l;
        f_size[p] = s;
        if (p == 1) begin
            d_if.req = 1'b1; d_if.addr = a; d_if.len = l; d_if.size = s; pend_d = 1'b1;
        end else begin
            i_if.req = 1'b1; i_if.addr = a; i_if.len = l; i_if.size = s; pend_i = 1'b1;
        end
    endtask

    // Call at a negedge with the DUT idle and requests already driven.
    // abort_at >= 0 pulses areset while that beat is on the bus.
    task automatic serve_one(input int abort_at);
        int          w;
        int          dly;
        int          g;
        logic [31:0] dat;
        logic [1:0]  resp;
        logic [3:0]  exp_id;

        if (!pend_i && !pend_d) return;
        if (pend_i && pend_d) w = RR_EN ? (last_d ? 0 : 1) : 1;
        else                  w = pend_d ? 1 : 0;
        exp_id = (w == 1) ? DFLT_ID_D : DFLT_ID_I;

        @(negedge aclk);
        chk("gnt_winner", (w == 1) ? d_if.gnt : i_if.gnt, 1'b1);
        chk("gnt_loser",  (w == 1) ? i_if.gnt : d_if.gnt, 1'b0);
        chk("arvalid_up", axi_if.arvalid, 1'b1);
        chk("araddr",     axi_if.araddr,  f_addr[w]);
        chk("arlen",      axi_if.arlen,   f_len[w]);
        chk("arsize",     axi_if.arsize,  f_size[w]);
        chk("arid",       axi_if.arid,    exp_id);
        chk("arburst",    axi_if.arburst, 2'b01);
        if (w == 1) begin d_if.req = 1'b0; pend_d = 1'b0; end
        else        begin i_if.req = 1'b0; pend_i = 1'b0; end
        last_d = (w == 1);

        dly = (ar_dly_fix >= 0) ? ar_dly_fix : $urandom_range(0, 3);
        for (int k = 0; k < dly; k++) begin
            axi_if.arready = 1'b0;
            @(negedge aclk);
            chk("ar_hold_vld",  axi_if.arvalid, 1'b1);
            chk("ar_hold_addr", axi_if.araddr,  f_addr[w]);
            chk("ar_hold_len",  axi_if.arlen,   f_len[w]);
            chk("ar_hold_size", axi_if.arsize,  f_size[w]);
            chk("ar_hold_id",   axi_if.arid,    exp_id);
            chk("gnt_pulse",    {i_if.gnt, d_if.gnt}, 2'b00);
        end
        axi_if.arready = 1'b1;
        @(negedge aclk);
        axi_if.arready = 1'b0;
        chk("ar_done",   axi_if.arvalid, 1'b0);
        chk("rready_on", axi_if.rready,  1'b1);
        chk("gnt_clear", {i_if.gnt, d_if.gnt}, 2'b00);

        for (int b = 0; b <= int'(f_len[w]); b++) begin
            g = (gaps.size() > 0) ? gaps.pop_front() : $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
                axi_if.rvalid = 1'b0;
                #1;
                chk("gap_vld", {i_if.rvalid, d_if.rvalid}, 2'b00);
                @(negedge aclk);
            end
            dat  = $urandom;
            resp = (rresp_fix >= 0) ? 2'(rresp_fix)
                                    : (($urandom_range(0, 3) == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = dat;
            axi_if.rresp  = resp;
            axi_if.rlast  = (b == int'(f_len[w]));
            axi_if.rid    = 4'($urandom);
            #1;
            chk("beat_vld",   (w == 1) ? d_if.rvalid : i_if.rvalid, 1'b1);
            chk("beat_dat",   (w == 1) ? d_if.rdata  : i_if.rdata,  dat);
            chk("beat_last",  (w == 1) ? d_if.rlast  : i_if.rlast,  b == int'(f_len[w]));
            chk("beat_err",   (w == 1) ? d_if.rerr   : i_if.rerr,   resp[1]);
            chk("nonown_vld", (w == 1) ? i_if.rvalid : d_if.rvalid, 1'b0);
            if (b == abort_at) begin
                areset = 1'b1;
                #1;
                chk("rst_arvalid", axi_if.arvalid, 1'b0);
                chk("rst_rready",  axi_if.rready,  1'b0);
                chk("rst_rvalid",  {i_if.rvalid, d_if.rvalid}, 2'b00);
                chk("rst_rdata",   i_if.rdata | d_if.rdata, 32'h0);
                chk("rst_rlast",   {i_if.rlast, d_if.rlast, i_if.rerr, d_if.rerr}, 4'h0);
                chk("rst_araddr",  axi_if.araddr, 32'h0);
                i_if.req = 1'b0; d_if.req = 1'b0;
                pend_i = 1'b0;   pend_d = 1'b0;
                last_d = 1'b0;
                axi_if.rvalid = 1'b0;
                axi_if.rlast  = 1'b0;
                @(negedge aclk);
                areset = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        chk("rready_off", axi_if.rready, 1'b0);
    endtask

    initial begin
        areset = 1'b1;
        i_if.req = 1'b0; i_if.addr = '0; i_if.len = '0; i_if.size = '0;
        d_if.req = 1'b0; d_if.addr = '0; d_if.len = '0; d_if.size = '0;
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rdata = '0;
        axi_if.rresp = '0; axi_if.rlast = 1'b0; axi_if.rid = '0;
        last_d = 1'b0; pend_i = 1'b0; pend_d = 1'b0;

        repeat (3) @(negedge aclk);
        chk("reset_arvalid", axi_if.arvalid, 1'b0);
        chk("reset_rready",  axi_if.rready,  1'b0);
        chk("reset_gnt",     {i_if.gnt, d_if.gnt, i_if.rvalid, d_if.rvalid}, 4'h0);
        chk("reset_ar",      {axi_if.araddr, axi_if.arlen, axi_if.arsize, axi_if.arid}, 43'h0);
        chk("reset_last",    {i_if.rlast, d_if.rlast, i_if.rerr, d_if.rerr}, 4'h0);
        areset = 1'b0;

        // Fetch-only burst, no stalls
        ar_dly_fix = 0;
        gaps = '{0, 0, 0, 0};
        set_req(0, 32'hBFC0_0000, 4'd3, 3'd2);
        serve_one(-1);
        ar_dly_fix = -1;

        // Simultaneous requests, then D comes back while I is still waiting
        set_req(0, 32'h0000_1000, 4'd1, 3'd2);
        set_req(1, 32'h8000_2000, 4'd2, 3'd2);
        serve_one(-1);
        set_req(1, 32'h8000_3000, 4'd0, 3'd1);
        serve_one(-1);
        serve_one(-1);

        // Long AR stall
        ar_dly_fix = 5;
        set_req(1, 32'h1234_5678, 4'd1, 3'd2);
        serve_one(-1);
        ar_dly_fix = -1;

        // Single-beat error response
        rresp_fix = 2;
        set_req(1, 32'h0000_0040, 4'd0, 3'd2);
        serve_one(-1);
        rresp_fix = -1;

        // rvalid pattern 1,0,0,1,1
        gaps = '{0, 2, 0};
        set_req(0, 32'h0000_0080, 4'd2, 3'd2);
        serve_one(-1);

        // Reset during the second beat, then a clean burst
        gaps = '{0, 0};
        set_req(0, 32'h0000_0100, 4'd3, 3'd2);
        serve_one(1);
        set_req(0, 32'h0000_0200, 4'd3, 3'd2);
        serve_one(-1);

        // Random mix of requests
        for (int it = 0; it < 40; it++) begin
            if (!pend_i && ($urandom_range(0, 1) == 1))
                set_req(0, $urandom, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
            if (!pend_d && ($urandom_range(0, 1) == 1))
                set_req(1, $urandom, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
            if (!pend_i && !pend_d)
                set_req(it % 2, $urandom, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
            serve_one(-1);
        end
        serve_one(-1);
        serve_one(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
